// File: rtl/fine_gain_pkg.sv
// Shared constants and helpers for the ramped fine-gain block: pipeline depth,
// channel-select width and the round-half-up / saturate step applied to products.
package fine_gain_pkg;

  localparam int LATENCY = 3;

  typedef struct packed {
    logic signed [31:0] value;
    logic               sat;
  } rs_t;

  // Width of the channel-select port; a single channel still gets one bit.
  function automatic int ch_sel_w(input int num_ch);
    int w;
    if (num_ch <= 2) begin
      w = 1;
    end else begin
      w = $clog2(num_ch);
    end
    return w;
  endfunction

  // Round a Q1.(gw-1)-scaled product half up and clamp it to a dw-bit signed range.
  function automatic rs_t round_sat(input logic signed [63:0] prod,
                                    input int dw, input int gw);
    logic signed [63:0] rounded;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    rs_t                r;
    rounded = (prod + (64'sd1 <<< (gw - 2))) >>> (gw - 1);
    max_v   = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (dw - 1));
    if (rounded > max_v) begin
      r.value = 32'(max_v);
      r.sat   = 1'b1;
    end else if (rounded < min_v) begin
      r.value = 32'(min_v);
      r.sat   = 1'b1;
    end else begin
      r.value = 32'(rounded);
      r.sat   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fine_gain_ramped_gain_slew.sv
// Per-channel gain slew limiter: holds the host target and the applied gain,
// and walks the applied gain toward the target by step_i on each valid sample.
module gain_slew
  import fine_gain_pkg::*;
#(
  parameter int GW = 18
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic                 wr_i,
  input  logic signed [GW-1:0] target_i,
  input  logic        [GW-2:0] step_i,
  output logic signed [GW-1:0] applied_o,
  output logic                 busy_o
);

  logic signed [GW-1:0] target_q;
  logic signed [GW-1:0] target_d;
  logic signed [GW-1:0] applied_q;
  logic signed [GW-1:0] applied_d;
  logic                 busy_q;
  logic signed [GW:0]   diff_s;
  logic        [GW:0]   mag_s;
  logic        [GW:0]   step_ext_s;

  // Next applied gain: the difference is taken one bit wider so it never wraps.
  always_comb begin
    diff_s     = {target_q[GW-1], target_q} - {applied_q[GW-1], applied_q};
    step_ext_s = {2'b00, step_i};
    if (diff_s[GW]) begin
      mag_s = $unsigned(-diff_s);
    end else begin
      mag_s = $unsigned(diff_s);
    end
    applied_d = applied_q;
    if (valid_i) begin
      if ((step_i == {(GW-1){1'b0}}) || (mag_s <= step_ext_s)) begin
        applied_d = target_q;
      end else if (diff_s[GW]) begin
        applied_d = applied_q - $signed({1'b0, step_i});
      end else begin
        applied_d = applied_q + $signed({1'b0, step_i});
      end
    end else begin
      applied_d = applied_q;
    end
  end

  // Target update; a write on a valid edge only takes effect for the next slew.
  always_comb begin
    target_d = target_q;
    if (wr_i) begin
      target_d = target_i;
    end else begin
      target_d = target_q;
    end
  end

  // Gain state registers; busy is registered from the next state so it tracks the state exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_q  <= {GW{1'b0}};
      applied_q <= {GW{1'b0}};
      busy_q    <= 1'b0;
    end else begin
      target_q  <= target_d;
      applied_q <= applied_d;
      busy_q    <= (applied_d != target_d);
    end
  end

  assign applied_o = applied_q;
  assign busy_o    = busy_q;

endmodule

// File: rtl/fine_gain_ramped.sv
// Multi-channel fine-gain stage with slew-limited gain changes.
// S1 captures samples and applied gains, S2 multiplies, S3 rounds and saturates.
module fine_gain_ramped
  import fine_gain_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 18
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    data_i,
  input  logic                            valid_i,
  input  logic signed [GAIN_WIDTH-1:0]    gain_target_i,
  input  logic [ch_sel_w(NUM_CH)-1:0]     gain_ch_i,
  input  logic                            gain_wr_i,
  input  logic [GAIN_WIDTH-2:0]           step_i,
  output logic [NUM_CH*DATA_WIDTH-1:0]    data_o,
  output logic                            valid_o,
  output logic [NUM_CH-1:0]               sat_o,
  output logic [NUM_CH-1:0]               ramp_busy_o
);

  localparam int CSW = ch_sel_w(NUM_CH);
  localparam int DW  = DATA_WIDTH;
  localparam int GW  = GAIN_WIDTH;
  localparam int PW  = DW + GW;

  logic valid_s1_q;
  logic valid_s2_q;
  logic valid_o_q;

  // Valid pipeline, cleared by reset so no in-flight sample survives it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_s1_q <= 1'b0;
      valid_s2_q <= 1'b0;
      valid_o_q  <= 1'b0;
    end else begin
      valid_s1_q <= valid_i;
      valid_s2_q <= valid_s1_q;
      valid_o_q  <= valid_s2_q;
    end
  end

  assign valid_o = valid_o_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [CSW-1:0] CH_IDX = CSW'(c);

    logic                 wr_s;
    logic signed [GW-1:0] applied_s;
    logic                 busy_s;
    logic signed [DW-1:0] data_s1_q;
    logic signed [GW-1:0] gain_s1_q;
    logic signed [PW-1:0] prod_q;
    rs_t                  rs_s;
    logic signed [DW-1:0] data_o_q;
    logic                 sat_o_q;

    // Out-of-range channel selects never match any lane, so those writes are dropped.
    assign wr_s = gain_wr_i && (gain_ch_i == CH_IDX);

    gain_slew #(
      .GW(GW)
    ) u_slew (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .valid_i  (valid_i),
      .wr_i     (wr_s),
      .target_i (gain_target_i),
      .step_i   (step_i),
      .applied_o(applied_s),
      .busy_o   (busy_s)
    );

    // S1 samples the gain as it was before this edge's slew update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_s1_q <= {DW{1'b0}};
        gain_s1_q <= {GW{1'b0}};
      end else begin
        data_s1_q <= data_i[c*DW +: DW];
        gain_s1_q <= applied_s;
      end
    end

    // S2 full-precision signed product, kept as a bare registered multiply.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prod_q <= {PW{1'b0}};
      end else begin
        prod_q <= data_s1_q * gain_s1_q;
      end
    end

    // Round half up and clamp the product back to the sample width.
    always_comb begin
      rs_s = round_sat({{(64-PW){prod_q[PW-1]}}, prod_q}, DW, GW);
    end

    // S3 output registers hold their value between valid samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        data_o_q <= {DW{1'b0}};
        sat_o_q  <= 1'b0;
      end else if (valid_s2_q) begin
        data_o_q <= DW'(rs_s.value);
        sat_o_q  <= rs_s.sat;
      end else begin
        data_o_q <= data_o_q;
        sat_o_q  <= sat_o_q;
      end
    end

    assign data_o[c*DW +: DW] = data_o_q;
    assign sat_o[c]           = sat_o_q;
    assign ramp_busy_o[c]     = busy_s;
  end

endmodule
